// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard
// Brief    : PS/2 keyboard front end for the Apple 1 core. Receives 11-bit
//            device-to-host frames, checks parity and stop, decodes scan code
//            set 2 with Shift/Ctrl tracking, and presents 7-bit uppercase
//            ASCII through a valid/read handshake. Single clk25 domain.
// Options  : PS2_FIFO_EN - when defined, a 4-entry character FIFO replaces
//            the single holding register ahead of the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       kbd_rd,
  output logic [6:0] kbd_data,
  output logic       kbd_valid,
  output logic       kbd_overflow,
  output logic       parity_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [1:0]     clk_sync;
  logic [1:0]     din_sync;
  logic           clk_s;
  logic           din_s;
  logic           filt_clk;
  logic           filt_prev;
  logic [FCW-1:0] filt_cnt;
  logic           sample_strobe;

  state_t         state;
  logic [3:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [15:0]    tmo_cnt;
  logic           stop_now;
  logic           frame_ok;

  logic           e0_flag;
  logic           brk_flag;
  logic           shift_flag;
  logic           ctrl_flag;
  logic           key_hit;
  logic [6:0]     key_char;
  logic           dec_valid;
  logic [6:0]     dec_char;

  // Two-flop synchronizers on both raw PS/2 lines (idle level is high)
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      din_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      din_sync <= {din_sync[0], ps2_din};
    end
  end

  assign clk_s = clk_sync[1];
  assign din_s = din_sync[1];

  // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // One-cycle strobe on each filtered falling edge; data is sampled here
  assign sample_strobe = filt_prev & ~filt_clk;

  assign stop_now = sample_strobe && (state == RECV) && (bitcnt == 4'd9);
  // Odd parity over data+parity and a high stop bit make a good frame
  assign frame_ok = stop_now && din_s && (^{shreg, par_bit});

  // Frame receiver: start, 8 data LSB first, parity, stop, with inactivity abort
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (sample_strobe && !din_s) begin
            state  <= RECV;
            bitcnt <= '0;
          end
        end
        RECV: begin
          if (sample_strobe) begin
            tmo_cnt <= '0;
            if (bitcnt < 4'd8) begin
              shreg <= {din_s, shreg[7:1]};
            end else if (bitcnt == 4'd8) begin
              par_bit <= din_s;
            end
            if (bitcnt == 4'd9) begin
              state      <= IDLE;
              parity_err <= !frame_ok;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else if (tmo_cnt == 16'(TIMEOUT_CYCLES)) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan code set 2 (US layout) to Apple 1 ASCII; {hit, char}
  function automatic logic [7:0] map_key(input logic [7:0] code,
                                         input logic       shift,
                                         input logic       ctrl);
    logic [6:0] ch;
    logic       hit;
    ch  = '0;
    hit = 1'b1;
    case (code)
      8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;
      8'h23: ch = 7'h44;  8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;
      8'h34: ch = 7'h47;  8'h33: ch = 7'h48;  8'h43: ch = 7'h49;
      8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
      8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;
      8'h4D: ch = 7'h50;  8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;
      8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;  8'h3C: ch = 7'h55;
      8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
      8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
      8'h45: ch = shift ? 7'h29 : 7'h30;
      8'h16: ch = shift ? 7'h21 : 7'h31;
      8'h1E: ch = shift ? 7'h40 : 7'h32;
      8'h26: ch = shift ? 7'h23 : 7'h33;
      8'h25: ch = shift ? 7'h24 : 7'h34;
      8'h2E: ch = shift ? 7'h25 : 7'h35;
      8'h36: ch = shift ? 7'h5E : 7'h36;
      8'h3D: ch = shift ? 7'h26 : 7'h37;
      8'h3E: ch = shift ? 7'h2A : 7'h38;
      8'h46: ch = shift ? 7'h28 : 7'h39;
      8'h4E: ch = shift ? 7'h5F : 7'h2D;
      8'h55: ch = shift ? 7'h2B : 7'h3D;
      8'h4C: ch = shift ? 7'h3A : 7'h3B;
      8'h52: ch = shift ? 7'h22 : 7'h27;
      8'h41: ch = shift ? 7'h3C : 7'h2C;
      8'h49: ch = shift ? 7'h3E : 7'h2E;
      8'h4A: ch = shift ? 7'h3F : 7'h2F;
      // Shifted brackets/backslash land in the lowercase range: dropped
      8'h54: begin ch = 7'h5B; hit = !shift; end
      8'h5B: begin ch = 7'h5D; hit = !shift; end
      8'h5D: begin ch = 7'h5C; hit = !shift; end
      8'h5A: ch = 7'h0D;
      8'h29: ch = 7'h20;
      8'h66: ch = 7'h5F;
      8'h76: ch = 7'h1B;
      default: hit = 1'b0;
    endcase
    if (ctrl && (ch >= 7'h41) && (ch <= 7'h5A)) begin
      ch = ch & 7'h1F;
    end
    return {hit, ch};
  endfunction

  assign {key_hit, key_char} = map_key(shreg, shift_flag, ctrl_flag);

  // Prefix/modifier tracking and the decode register
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      e0_flag    <= 1'b0;
      brk_flag   <= 1'b0;
      shift_flag <= 1'b0;
      ctrl_flag  <= 1'b0;
      dec_valid  <= 1'b0;
      dec_char   <= '0;
    end else begin
      dec_valid <= 1'b0;
      if (frame_ok) begin
        if (shreg == 8'hE0) begin
          e0_flag <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          e0_flag  <= 1'b0;
          brk_flag <= 1'b0;
          if ((shreg == 8'h12 || shreg == 8'h59) && !e0_flag) begin
            shift_flag <= !brk_flag;
          end else if (shreg == 8'h14) begin
            ctrl_flag <= !brk_flag;
          end else if (!brk_flag && !e0_flag && key_hit) begin
            dec_valid <= 1'b1;
            dec_char  <= key_char;
          end
        end
      end
    end
  end

`ifdef PS2_FIFO_EN
  logic [6:0] fifo_mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  logic       pop;
  logic       push_ok;

  // A pop frees a slot before the push is considered, so full+pop+push succeeds
  assign pop     = kbd_rd && (count != 3'd0);
  assign push_ok = dec_valid && ((count != 3'd4) || pop);

  // Four-entry character queue ahead of the consumer
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      kbd_overflow <= dec_valid && !push_ok;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= dec_char;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign kbd_data  = fifo_mem[rd_ptr];
  assign kbd_valid = (count != 3'd0);
`else
  // Single holding register: a character arriving while one is unread is dropped
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      kbd_data     <= '0;
      kbd_valid    <= 1'b0;
      kbd_overflow <= 1'b0;
    end else begin
      kbd_overflow <= 1'b0;
      if (dec_valid) begin
        if (kbd_valid && !kbd_rd) begin
          kbd_overflow <= 1'b1;
        end else begin
          kbd_data  <= dec_char;
          kbd_valid <= 1'b1;
        end
      end else if (kbd_rd) begin
        kbd_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard
// Brief    : Self-checking bench for ps2_keyboard. A driver emits PS/2 frames
//            while a keyboard model predicts characters into a queue; a
//            monitor pops and compares whenever kbd_valid is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;

  localparam int HP = 16;   // PS/2 half period in clk25 cycles
`ifdef PS2_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk25   = 1'b0;
  logic       rst_n   = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_din = 1'b1;
  logic       kbd_rd  = 1'b0;
  logic [6:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_overflow;
  logic       parity_err;

  ps2_keyboard dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_din     (ps2_din),
    .kbd_rd      (kbd_rd),
    .kbd_data    (kbd_data),
    .kbd_valid   (kbd_valid),
    .kbd_overflow(kbd_overflow),
    .parity_err  (parity_err)
  );

  always #20 clk25 = ~clk25;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_strobe = -100;
  logic [6:0] exp_q[$];
  int         pending = 0;
  int         exp_perr = 0;
  int         exp_ovf = 0;
  int         seen_perr = 0;
  int         seen_ovf = 0;
  bit         auto_rd = 1'b1;
  bit         vprev = 1'b0;
  bit         m_e0, m_brk, m_shift, m_ctrl;
  logic [7:0] plain_map [256];
  logic [7:0] shift_map [256];
  logic [7:0] pool[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put(input logic [7:0] code, input logic [7:0] pl, input logic [7:0] sh);
    plain_map[code] = pl;
    shift_map[code] = sh;
  endtask

  // Keyboard model: what a US keyboard feeding an uppercase-only terminal yields
  task automatic model(input logic [7:0] b, input bit bad);
    logic [7:0] ch;
    if (bad) begin
      exp_perr++;
      return;
    end
    if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if ((b == 8'h12 || b == 8'h59) && !m_e0) m_shift = !m_brk;
      else if (b == 8'h14) m_ctrl = !m_brk;
      else if (!m_brk && !m_e0 && plain_map[b] != 8'h00) begin
        ch = m_shift ? shift_map[b] : plain_map[b];
        if (m_ctrl && ch >= "A" && ch <= "Z") ch = ch & 8'h1F;
        if (pending >= CAP) exp_ovf++;
        else begin
          exp_q.push_back(ch[6:0]);
          pending++;
        end
      end
      m_e0  = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Drive the first nbits of a frame (bit 0 first), data set while clock is high
  task automatic frame_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_din = bits[i];
      repeat (HP) @(negedge clk25);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk25);
      ps2_clk = 1'b1;
    end
  endtask

  // bad: 0 = good frame, 1 = wrong parity, 2 = stop bit low
  task automatic send_byte(input logic [7:0] b, input int bad);
    logic par;
    logic stp;
    par = ~^b;
    stp = 1'b1;
    if (bad == 1) par = ~par;
    if (bad == 2) stp = 1'b0;
    model(b, bad != 0);
    frame_bits({stp, par, b, 1'b0}, 11);
    ps2_din = 1'b1;
    repeat (24) @(negedge clk25);
    check("parity_err_count", seen_perr, exp_perr);
    check("overflow_count", seen_ovf, exp_ovf);
    if (auto_rd) check("queue_drained", exp_q.size(), 0);
  endtask

  always @(posedge clk25) cyc = cyc + 1;

  // Monitor: pulse counting, latency, and scoreboard pops on each presented character
  initial begin : monitor
    forever begin
      @(negedge clk25);
      if (dut.sample_strobe) last_strobe = cyc;
      if (parity_err) seen_perr++;
      if (kbd_overflow) seen_ovf++;
      if (kbd_valid && !vprev) check("valid_latency", cyc - last_strobe, 2);
      if (kbd_rd) begin
        kbd_rd = 1'b0;
        if (pending == 0) check("valid_after_rd", kbd_valid, 0);
      end else if (kbd_valid && auto_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got 0x%0h, expected none (t=%0t)", kbd_data, $time);
        end else begin
          check("char", kbd_data, exp_q.pop_front());
          pending--;
        end
        kbd_rd = 1'b1;
      end
      vprev = kbd_valid;
    end
  end

  initial begin : watchdog
    repeat (98000) @(posedge clk25);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    int         bad;
    for (int i = 0; i < 256; i++) begin
      plain_map[i] = 8'h00;
      shift_map[i] = 8'h00;
    end
    put(8'h1C,"A","A"); put(8'h32,"B","B"); put(8'h21,"C","C"); put(8'h23,"D","D");
    put(8'h24,"E","E"); put(8'h2B,"F","F"); put(8'h34,"G","G"); put(8'h33,"H","H");
    put(8'h43,"I","I"); put(8'h3B,"J","J"); put(8'h42,"K","K"); put(8'h4B,"L","L");
    put(8'h3A,"M","M"); put(8'h31,"N","N"); put(8'h44,"O","O"); put(8'h4D,"P","P");
    put(8'h15,"Q","Q"); put(8'h2D,"R","R"); put(8'h1B,"S","S"); put(8'h2C,"T","T");
    put(8'h3C,"U","U"); put(8'h2A,"V","V"); put(8'h1D,"W","W"); put(8'h22,"X","X");
    put(8'h35,"Y","Y"); put(8'h1A,"Z","Z");
    put(8'h45,"0",")"); put(8'h16,"1","!"); put(8'h1E,"2","@"); put(8'h26,"3","#");
    put(8'h25,"4","$"); put(8'h2E,"5","%"); put(8'h36,"6","^"); put(8'h3D,"7","&");
    put(8'h3E,"8","*"); put(8'h46,"9","(");
    put(8'h4E,"-","_"); put(8'h55,"=","+"); put(8'h4C,";",":"); put(8'h52,"'","\"");
    put(8'h41,",","<"); put(8'h49,".",">"); put(8'h4A,"/","?");
    put(8'h5A,8'h0D,8'h0D); put(8'h29,8'h20,8'h20); put(8'h66,8'h5F,8'h5F); put(8'h76,8'h1B,8'h1B);
    pool = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,
             8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,
             8'h35,8'h1A,8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
             8'h4E,8'h55,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h5A,8'h29,8'h66,8'h76,
             8'h12,8'h59,8'h14,8'h12,8'h14,8'hE0,8'hF0,8'hF0,8'hF0,8'h05,8'h83};
    m_e0 = 1'b0; m_brk = 1'b0; m_shift = 1'b0; m_ctrl = 1'b0;

    // Reset state
    repeat (5) @(negedge clk25);
    check("reset_data", kbd_data, 0);
    check("reset_valid", kbd_valid, 0);
    check("reset_overflow", kbd_overflow, 0);
    check("reset_parity_err", parity_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);

    // Single make code, Shift sequence, Ctrl sequence
    send_byte(8'h1C, 0);
    foreach (pool[i]) if (i < 0) send_byte(pool[i], 0);
    send_byte(8'h12, 0); send_byte(8'h16, 0); send_byte(8'hF0, 0); send_byte(8'h16, 0);
    send_byte(8'hF0, 0); send_byte(8'h12, 0); send_byte(8'h16, 0);
    send_byte(8'h14, 0); send_byte(8'h34, 0); send_byte(8'hF0, 0); send_byte(8'h34, 0);
    send_byte(8'hF0, 0); send_byte(8'h14, 0);

    // Bad parity, bad stop, then a good frame
    send_byte(8'h1C, 1);
    send_byte(8'h1C, 2);
    send_byte(8'h32, 0);

    // Abandoned frame followed by more than the inactivity limit of silence
    frame_bits({2'b11, 8'h1C, 1'b0}, 5);
    ps2_din = 1'b1;
    repeat (50500) @(negedge clk25);
    check("timeout_no_parity_err", seen_perr, exp_perr);
    check("timeout_no_valid", kbd_valid, 0);
    send_byte(8'h5A, 0);

    // Unread characters: capacity fills, then the next one is dropped
    auto_rd = 1'b0;
    send_byte(8'h1C, 0); send_byte(8'h32, 0);
`ifdef PS2_FIFO_EN
    send_byte(8'h21, 0); send_byte(8'h23, 0); send_byte(8'h24, 0);
`endif
    check("held_valid", kbd_valid, 1);
    check("held_data", kbd_data, 8'h41);
    auto_rd = 1'b1;
    repeat (20) @(negedge clk25);
    check("backlog_drained", exp_q.size(), 0);

    // Randomized keystream through the model
    for (int n = 0; n < 40; n++) begin
      do b = pool[$urandom_range(0, pool.size() - 1)];
      while ((b == 8'h12 || b == 8'h59) && m_e0);
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_byte(b, bad);
    end

    // Reset in the middle of a frame while a character is held and Shift is down
    send_byte(8'h05, 0);
    auto_rd = 1'b0;
    send_byte(8'h12, 0);
    send_byte(8'h16, 0);
    check("pre_reset_valid", kbd_valid, (pending > 0) ? 1 : 0);
    frame_bits({2'b11, 8'h1C, 1'b0}, 4);
    #7 rst_n = 1'b0;
    #1;
    check("midreset_data", kbd_data, 0);
    check("midreset_valid", kbd_valid, 0);
    check("midreset_overflow", kbd_overflow, 0);
    check("midreset_parity_err", parity_err, 0);
    ps2_clk = 1'b1;
    ps2_din = 1'b1;
    exp_q.delete();
    pending = 0;
    m_e0 = 1'b0; m_brk = 1'b0; m_shift = 1'b0; m_ctrl = 1'b0;
    repeat (4) @(negedge clk25);
    rst_n = 1'b1;
    auto_rd = 1'b1;
    repeat (4) @(negedge clk25);
    send_byte(8'h16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
